// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR unit: mstatus.MIE/MPIE, mie, mip (read-only) and mcause,
// with fixed-priority MSI/MTI/MEI plus NUM_LIRQ local interrupts and 5-bit cause codes.
module serv_csr_irq #(
    parameter int NUM_LIRQ = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_init,
    input  logic                  i_en,
    input  logic [4:0]            i_cnt,
    input  logic                  i_cnt_done,
    input  logic                  i_trap,
    input  logic                  i_mret,
    input  logic                  i_e_op,
    input  logic                  i_ebreak,
    input  logic                  i_mem_op,
    input  logic                  i_mem_cmd,
    input  logic                  i_mstatus_en,
    input  logic                  i_mie_en,
    input  logic                  i_mip_en,
    input  logic                  i_mcause_en,
    input  logic [1:0]            i_csr_source,
    input  logic                  i_csr_d_sel,
    input  logic                  i_csr_imm,
    input  logic                  i_rs1,
    input  logic                  i_rf_csr_out,
    input  logic [3+NUM_LIRQ-1:0] i_irq,
    output logic                  o_csr_in,
    output logic                  o_q,
    output logic                  o_new_irq
);

    localparam int NI = 3 + NUM_LIRQ;

    // Bit position in mie/mip, which is also the interrupt's cause code.
    function automatic logic [4:0] irq_pos(input int n);
        logic [4:0] p;
        case (n)
            0:       p = 5'd3;
            1:       p = 5'd7;
            2:       p = 5'd11;
            default: p = 5'(n + 13);
        endcase
        return p;
    endfunction

    logic          mstatus_mie_q, mstatus_mie_d;
    logic          mpie_q, mpie_d;
    logic [NI-1:0] mie_q, mie_d;
    logic          mcause_int_q, mcause_int_d;
    logic [4:0]    mcause_code_q, mcause_code_d;
    logic          irq_r_q, irq_r_d;
    logic          new_irq_q, new_irq_d;
    logic [4:0]    irq_code_q, irq_code_d;

    logic          d_s;
    logic          q_s;
    logic          csr_in_s;
    logic          mcause_bit_s;
    logic          trap_done_s;
    logic [4:0]    exc_code_s;
    logic [NI-1:0] act_s;
    logic          pend_s;
    logic [4:0]    sel_code_s;

    assign d_s         = i_csr_d_sel ? i_csr_imm : i_rs1;
    assign trap_done_s = i_trap & i_cnt_done;
    assign act_s       = i_irq & mie_q;
    assign pend_s      = mstatus_mie_q & (|act_s);

    // Serial read bit: OR of every CSR source that owns the current bit index.
    always_comb begin
        case (i_cnt)
            5'd0:    mcause_bit_s = mcause_code_q[0];
            5'd1:    mcause_bit_s = mcause_code_q[1];
            5'd2:    mcause_bit_s = mcause_code_q[2];
            5'd3:    mcause_bit_s = mcause_code_q[3];
            5'd4:    mcause_bit_s = mcause_code_q[4];
            5'd31:   mcause_bit_s = mcause_int_q;
            default: mcause_bit_s = 1'b0;
        endcase
        q_s = i_rf_csr_out
            | (i_mstatus_en & (i_cnt == 5'd3) & mstatus_mie_q)
            | (i_mcause_en & i_en & mcause_bit_s);
        for (int n = 0; n < NI; n++) begin
            q_s = q_s | ((i_cnt == irq_pos(n)) & ((i_mie_en & mie_q[n]) | (i_mip_en & i_irq[n])));
        end
    end

    // New serial CSR bit from the keep/write/set/clear operation.
    always_comb begin
        case (i_csr_source)
            2'b00:   csr_in_s = q_s;
            2'b01:   csr_in_s = d_s;
            2'b10:   csr_in_s = q_s | d_s;
            2'b11:   csr_in_s = q_s & ~d_s;
            default: csr_in_s = q_s;
        endcase
    end

    assign o_q      = q_s;
    assign o_csr_in = csr_in_s;

    // Exception cause when no interrupt is being taken.
    always_comb begin
        if (i_e_op) begin
            exc_code_s = i_ebreak ? 5'd3 : 5'd11;
        end else if (i_mem_op) begin
            exc_code_s = i_mem_cmd ? 5'd6 : 5'd4;
        end else begin
            exc_code_s = 5'd0;
        end
    end

    // Fixed priority MEI > MSI > MTI > lowest-numbered local interrupt.
    always_comb begin
        if (act_s[2]) begin
            sel_code_s = 5'd11;
        end else if (act_s[0]) begin
            sel_code_s = 5'd3;
        end else if (act_s[1]) begin
            sel_code_s = 5'd7;
        end else begin
            sel_code_s = 5'd0;
            for (int k = NI - 1; k >= 3; k--) begin
                if (act_s[k]) begin
                    sel_code_s = irq_pos(k);
                end else begin
                    sel_code_s = sel_code_s;
                end
            end
        end
    end

    // mie enable bits are written only at their own serial position.
    always_comb begin
        mie_d = mie_q;
        for (int n = 0; n < NI; n++) begin
            if (i_mie_en && i_en && (i_cnt == irq_pos(n))) begin
                mie_d[n] = csr_in_s;
            end else begin
                mie_d[n] = mie_q[n];
            end
        end
    end

    // mstatus: a trap overrides mret and software writes.
    always_comb begin
        mstatus_mie_d = mstatus_mie_q;
        mpie_d        = mpie_q;
        if (trap_done_s) begin
            mstatus_mie_d = 1'b0;
            mpie_d        = mstatus_mie_q;
        end else if (i_mret) begin
            mstatus_mie_d = mpie_q;
        end else if (i_mstatus_en && i_en && (i_cnt == 5'd3)) begin
            mstatus_mie_d = csr_in_s;
        end else begin
            mstatus_mie_d = mstatus_mie_q;
        end
    end

    // mcause: trap capture, else serial software write of bits 0..4 and 31.
    always_comb begin
        mcause_int_d  = mcause_int_q;
        mcause_code_d = mcause_code_q;
        if (trap_done_s) begin
            if (new_irq_q) begin
                mcause_int_d  = 1'b1;
                mcause_code_d = irq_code_q;
            end else begin
                mcause_int_d  = 1'b0;
                mcause_code_d = exc_code_s;
            end
        end else if (i_mcause_en && i_en) begin
            case (i_cnt)
                5'd0:    mcause_code_d[0] = csr_in_s;
                5'd1:    mcause_code_d[1] = csr_in_s;
                5'd2:    mcause_code_d[2] = csr_in_s;
                5'd3:    mcause_code_d[3] = csr_in_s;
                5'd4:    mcause_code_d[4] = csr_in_s;
                5'd31:   mcause_int_d     = csr_in_s;
                default: mcause_int_d     = mcause_int_q;
            endcase
        end else begin
            mcause_int_d = mcause_int_q;
        end
    end

    // Interrupt edge detect, evaluated once per non-init word.
    always_comb begin
        if (!i_init && i_cnt_done) begin
            irq_r_d    = pend_s;
            new_irq_d  = pend_s & ~irq_r_q;
            irq_code_d = sel_code_s;
        end else begin
            irq_r_d    = irq_r_q;
            new_irq_d  = new_irq_q;
            irq_code_d = irq_code_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus_mie_q <= 1'b0;
            mpie_q        <= 1'b0;
            mie_q         <= '0;
            mcause_int_q  <= 1'b0;
            mcause_code_q <= 5'd0;
            irq_r_q       <= 1'b0;
            new_irq_q     <= 1'b0;
            irq_code_q    <= 5'd0;
        end else begin
            mstatus_mie_q <= mstatus_mie_d;
            mpie_q        <= mpie_d;
            mie_q         <= mie_d;
            mcause_int_q  <= mcause_int_d;
            mcause_code_q <= mcause_code_d;
            irq_r_q       <= irq_r_d;
            new_irq_q     <= new_irq_d;
            irq_code_q    <= irq_code_d;
        end
    end

    assign o_new_irq = new_irq_q;

endmodule

// File: tb/tb_serv_csr_irq.sv
// Self-checking bench for serv_csr_irq (NUM_LIRQ=2): directed scenarios plus random
// words checked against a word-level model of the CSR and interrupt rules.
module tb_serv_csr_irq;
    localparam int NUM_LIRQ = 2;
    localparam int NI = 3 + NUM_LIRQ;

    logic i_clk = 1'b0;
    logic i_rst, i_init, i_en, i_cnt_done, i_trap, i_mret, i_e_op, i_ebreak;
    logic i_mem_op, i_mem_cmd, i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en;
    logic [4:0] i_cnt;
    logic [1:0] i_csr_source;
    logic i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out;
    logic [NI-1:0] i_irq;
    logic o_csr_in, o_q, o_new_irq;

    serv_csr_irq #(.NUM_LIRQ(NUM_LIRQ)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_en(i_en), .i_cnt(i_cnt),
        .i_cnt_done(i_cnt_done), .i_trap(i_trap), .i_mret(i_mret), .i_e_op(i_e_op),
        .i_ebreak(i_ebreak), .i_mem_op(i_mem_op), .i_mem_cmd(i_mem_cmd),
        .i_mstatus_en(i_mstatus_en), .i_mie_en(i_mie_en), .i_mip_en(i_mip_en),
        .i_mcause_en(i_mcause_en), .i_csr_source(i_csr_source), .i_csr_d_sel(i_csr_d_sel),
        .i_csr_imm(i_csr_imm), .i_rs1(i_rs1), .i_rf_csr_out(i_rf_csr_out), .i_irq(i_irq),
        .o_csr_in(o_csr_in), .o_q(o_q), .o_new_irq(o_new_irq)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state, kept as architectural CSR values
    bit            m_mstatus_mie, m_mpie, m_irq_r, m_new_irq;
    bit [NI-1:0]   m_mie;
    bit [31:0]     m_mcause;
    bit [4:0]      m_code;
    logic [NI-1:0] cur_irq;
    logic [31:0]   last_q;

    function automatic int pos(input int n);
        if (n == 0) return 3;
        if (n == 1) return 7;
        if (n == 2) return 11;
        return 13 + n;
    endfunction

    function automatic logic [31:0] spread(input logic [NI-1:0] v);
        logic [31:0] w;
        w = 32'h0;
        for (int n = 0; n < NI; n++) w[pos(n)] = v[n];
        return w;
    endfunction

    function automatic logic [4:0] top_code(input logic [NI-1:0] act);
        int order [NI];
        order[0] = 2; order[1] = 0; order[2] = 1;
        for (int k = 3; k < NI; k++) order[k] = k;
        for (int i = 0; i < NI; i++) begin
            if (act[order[i]]) return 5'(pos(order[i]));
        end
        return 5'd0;
    endfunction

    function automatic logic [4:0] exc_code(input logic [3:0] exc);
        if (exc[3]) return exc[2] ? 5'd3 : 5'd11;
        if (exc[1]) return exc[0] ? 5'd6 : 5'd4;
        return 5'd0;
    endfunction

    task automatic idle_inputs();
        i_init = 1'b0; i_en = 1'b0; i_cnt = 5'd0; i_cnt_done = 1'b0;
        i_trap = 1'b0; i_mret = 1'b0; i_e_op = 1'b0; i_ebreak = 1'b0;
        i_mem_op = 1'b0; i_mem_cmd = 1'b0; i_mstatus_en = 1'b0; i_mie_en = 1'b0;
        i_mip_en = 1'b0; i_mcause_en = 1'b0; i_csr_source = 2'b00; i_csr_d_sel = 1'b0;
        i_csr_imm = 1'b0; i_rs1 = 1'b0; i_rf_csr_out = 1'b0; i_irq = cur_irq;
    endtask

    task automatic model_reset();
        m_mstatus_mie = 1'b0; m_mpie = 1'b0; m_irq_r = 1'b0; m_new_irq = 1'b0;
        m_mie = '0; m_mcause = 32'h0; m_code = 5'd0;
    endtask

    // tgt: 0 none, 1 mstatus, 2 mie, 3 mip, 4 mcause; exc = {e_op, ebreak, mem_op, mem_cmd}
    task automatic run_word(input bit init, input int tgt, input logic [1:0] src,
                            input logic [31:0] dw, input logic [31:0] rfw, input bit trap,
                            input bit mret, input logic [3:0] exc, input string tag);
        logic [31:0] csr_w, q_exp, in_exp, junk, got_q, got_in;
        logic [NI-1:0] act;
        bit dsel, pend, old_new;
        logic [4:0] old_code;
        dsel = 1'($urandom_range(0, 1));
        junk = $urandom;
        case (tgt)
            1:       csr_w = {28'h0, m_mstatus_mie, 3'b000};
            2:       csr_w = spread(m_mie);
            3:       csr_w = spread(cur_irq);
            4:       csr_w = m_mcause;
            default: csr_w = 32'h0;
        endcase
        q_exp = csr_w | rfw;
        case (src)
            2'b00:   in_exp = q_exp;
            2'b01:   in_exp = dw;
            2'b10:   in_exp = q_exp | dw;
            default: in_exp = q_exp & ~dw;
        endcase
        i_init = init; i_mstatus_en = (tgt == 1); i_mie_en = (tgt == 2);
        i_mip_en = (tgt == 3); i_mcause_en = (tgt == 4);
        i_csr_source = src; i_csr_d_sel = dsel; i_irq = cur_irq;
        i_trap = trap; i_mret = mret;
        {i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = exc;
        for (int c = 0; c < 32; c++) begin
            i_en = 1'b1; i_cnt = 5'(c); i_cnt_done = (c == 31);
            i_csr_imm = dsel ? dw[c] : junk[c];
            i_rs1 = dsel ? junk[c] : dw[c];
            i_rf_csr_out = rfw[c];
            @(negedge i_clk);
            got_q[c] = o_q;
            got_in[c] = o_csr_in;
            @(posedge i_clk);
            #1;
        end
        idle_inputs();
        if (mret) m_mstatus_mie = m_mpie;
        else if (tgt == 1) m_mstatus_mie = in_exp[3];
        if (tgt == 2) for (int n = 0; n < NI; n++) m_mie[n] = in_exp[pos(n)];
        if (tgt == 4) m_mcause = in_exp & 32'h8000_001F;
        old_new = m_new_irq;
        old_code = m_code;
        if (!init) begin
            act = cur_irq & m_mie;
            pend = m_mstatus_mie && (act != '0);
            m_new_irq = pend && !m_irq_r;
            m_irq_r = pend;
            m_code = top_code(act);
        end
        if (trap) begin
            m_mcause = old_new ? {1'b1, 26'h0, old_code} : {27'h0, exc_code(exc)};
            m_mpie = m_mstatus_mie;
            m_mstatus_mie = 1'b0;
        end
        last_q = got_q;
        n_vec++;
        if (got_q !== q_exp) begin
            n_err++;
            $display("FAIL %s o_q word: got %h want %h", tag, got_q, q_exp);
        end
        n_vec++;
        if (got_in !== in_exp) begin
            n_err++;
            $display("FAIL %s o_csr_in word: got %h want %h", tag, got_in, in_exp);
        end
        n_vec++;
        if (o_new_irq !== m_new_irq) begin
            n_err++;
            $display("FAIL %s o_new_irq: got %b want %b", tag, o_new_irq, m_new_irq);
        end
    endtask

    task automatic idle_word(input string tag);
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, tag);
    endtask

    task automatic csr_write(input int tgt, input logic [31:0] v, input string tag);
        run_word(1'b0, tgt, 2'b01, v, 32'h0, 1'b0, 1'b0, 4'h0, tag);
    endtask

    task automatic check_read(input int tgt, input logic [31:0] want, input string tag);
        run_word(1'b0, tgt, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, tag);
        n_vec++;
        if (last_q !== want) begin
            n_err++;
            $display("FAIL %s value: got %h want %h", tag, last_q, want);
        end
    endtask

    task automatic check_new_irq(input logic want, input string tag);
        n_vec++;
        if (o_new_irq !== want) begin
            n_err++;
            $display("FAIL %s new_irq: got %b want %b", tag, o_new_irq, want);
        end
    endtask

    task automatic test_reset();
        cur_irq = '0;
        idle_inputs();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        check_new_irq(1'b0, "reset");
        check_read(2, 32'h0, "reset_mie");
        check_read(3, 32'h0, "reset_mip");
        check_read(4, 32'h0, "reset_mcause");
        check_read(1, 32'h0, "reset_mstatus");
    endtask

    task automatic test_mtip();
        csr_write(2, 32'h80, "mtip_mie");
        csr_write(1, 32'h8, "mtip_mstatus");
        cur_irq = 5'b00010;
        idle_word("mtip_raise");
        check_new_irq(1'b1, "mtip_raised");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, "mtip_trap");
        check_new_irq(1'b0, "mtip_one_word");
        check_read(4, 32'h8000_0007, "mtip_mcause");
        check_read(1, 32'h0, "mtip_mstatus");
        cur_irq = '0;
        idle_word("mtip_idle");
    endtask

    task automatic test_priority();
        csr_write(2, 32'h888, "prio_mie");
        cur_irq = 5'b00111;
        idle_word("prio_idle");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, "prio_mret");
        check_new_irq(1'b1, "prio_raised");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, "prio_trap");
        check_read(4, 32'h8000_000B, "prio_mei");
        cur_irq = 5'b00011;
        idle_word("prio_drop");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, "prio_mret2");
        check_new_irq(1'b1, "prio_retrigger");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, "prio_trap2");
        check_read(4, 32'h8000_0003, "prio_msi");
        cur_irq = '0;
        idle_word("prio_idle2");
    endtask

    task automatic test_local();
        csr_write(2, 32'h2_0000, "local_mie");
        cur_irq = 5'b10000;
        csr_write(1, 32'h8, "local_mstatus");
        check_new_irq(1'b1, "local1_raised");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, "local_trap");
        check_read(4, 32'h8000_0011, "local1_mcause");
        cur_irq = 5'b11000;
        csr_write(2, 32'h3_0000, "local_mie2");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, "local_mret");
        run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, "local_trap2");
        check_read(4, 32'h8000_0010, "local0_mcause");
        cur_irq = '0;
        idle_word("local_idle");
        idle_word("local_idle2");
    endtask

    task automatic test_exceptions();
        logic [3:0]  excs  [5] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b0000};
        logic [31:0] wants [5] = '{32'd11, 32'd3, 32'd6, 32'd4, 32'd0};
        cur_irq = '0;
        for (int i = 0; i < 5; i++) begin
            check_new_irq(1'b0, "exc_no_irq");
            run_word(1'b0, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, excs[i], "exc_trap");
            check_read(4, wants[i], "exc_mcause");
        end
    endtask

    task automatic test_set_clear();
        csr_write(2, 32'h80, "sc_mie");
        run_word(1'b0, 2, 2'b10, 32'h800, 32'h0, 1'b0, 1'b0, 4'h0, "sc_set");
        check_read(2, 32'h880, "sc_after_set");
        run_word(1'b0, 2, 2'b11, 32'h800, 32'h0, 1'b0, 1'b0, 4'h0, "sc_clear");
        check_read(2, 32'h80, "sc_after_clear");
        cur_irq = 5'b00101;
        csr_write(3, 32'hFFFF_FFFF, "mip_write");
        check_read(3, 32'h808, "mip_unchanged");
        cur_irq = '0;
        idle_word("sc_idle");
    endtask

    task automatic test_mid_word_reset();
        csr_write(2, 32'hFFFF_FFFF, "mwr_mie");
        csr_write(1, 32'h8, "mwr_mstatus");
        csr_write(4, 32'h8000_0015, "mwr_mcause");
        i_mcause_en = 1'b1; i_csr_source = 2'b01; i_rs1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_en = 1'b1; i_cnt = 5'(c);
            @(posedge i_clk);
            #1;
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle_inputs();
        model_reset();
        check_new_irq(1'b0, "mwr_new_irq");
        check_read(2, 32'h0, "mwr_mie_read");
        check_read(4, 32'h0, "mwr_mcause_read");
        check_read(1, 32'h0, "mwr_mstatus_read");
    endtask

    task automatic test_random();
        int tgt;
        int kind;
        bit trap, mret, init;
        logic [31:0] dw, rfw;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) cur_irq = NI'($urandom);
            tgt  = $urandom_range(0, 4);
            kind = $urandom_range(0, 9);
            trap = (kind < 2);
            mret = (kind == 2);
            if (mret && tgt == 1) tgt = 0;
            init = ($urandom_range(0, 3) == 0);
            dw   = $urandom;
            rfw  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            run_word(init, tgt, 2'($urandom_range(0, 3)), dw, rfw, trap, mret,
                     4'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        cur_irq = '0;
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_mtip();
        test_priority();
        test_local();
        test_exceptions();
        test_set_clear();
        test_mid_word_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
